// File: rtl/mod_inverse_seq_pkg.sv
// Shared constants for the sequential modular inverter.
// FSM encoding, default width and the step-bound helpers.
package mod_inverse_seq_pkg;

  localparam int DATAWIDTH = 15;
  localparam int WIDTH_DEF = DATAWIDTH + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_DONE_ERR = 2'd2;

  function automatic int max_steps(input int w);
    return 4 * w + 2;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(max_steps(w) + 1);
  endfunction

endpackage

// File: rtl/mod_inverse_seq_half.sv
// Modular halving: x even ? x/2 : (x+p)/2.
// The sum keeps its carry so the shift never loses the top bit.
module mod_half #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH:0] sum;

  assign sum = x_i[0] ? ({1'b0, x_i} + {1'b0, p_i})
                      : {1'b0, x_i};
  assign y_o = sum[WIDTH:1];

endmodule

// File: rtl/mod_inverse_seq.sv
// Binary extended Euclid inverse, one reduction per clock.
// Bounded step counter guarantees termination on bad inputs.
module mod_inverse_seq
  import mod_inverse_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int MAX_STEPS = max_steps(WIDTH);
  localparam int CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STEPS - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0] pm_q, pm_d, res_q, res_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] x1_half, x2_half;
  logic [WIDTH-1:0] x1_sub, x2_sub;

  mod_half #(.WIDTH(WIDTH)) u_half1 (
    .x_i(x1_q), .p_i(pm_q), .y_o(x1_half)
  );

  mod_half #(.WIDTH(WIDTH)) u_half2 (
    .x_i(x2_q), .p_i(pm_q), .y_o(x2_half)
  );

  // Borrow case adds pm - y first so no intermediate overflows.
  assign x1_sub = (x1_q >= x2_q) ? x1_q - x2_q
                                 : x1_q + (pm_q - x2_q);
  assign x2_sub = (x2_q >= x1_q) ? x2_q - x1_q
                                 : x2_q + (pm_q - x1_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    pm_d    = pm_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pm_d    = p;
          u_d     = a;
          v_d     = p;
          x1_d    = ONE;
          x2_d    = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = (a == '0) ? S_DONE_ERR : S_RUN;
        end
      end
      S_DONE_ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        res_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (u_q == ONE) begin
          res_d   = x1_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (v_q == ONE) begin
          res_d   = x2_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_sub;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_sub;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      pm_q    <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      pm_q    <= pm_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = res_q;

endmodule
